// File: rtl/robot_mode_controller.sv
// ============================================================================
//  Module      : robot_mode_controller
//  Description : Mode FSM for the robot (IDLE/MANUAL/SEARCH/TRACK/HALT)
//                driven by IR remote codes and camera target detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module robot_mode_controller #(
    parameter int MANUAL_HOLD    = 25_000_000,
    parameter int ACQUIRE_CYCLES = 1_250_000,
    parameter int LOST_TIMEOUT   = 50_000_000
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       ir_valid,
    input  logic [7:0] IR_button,
    input  logic [2:0] cam_direction,
    input  logic       orange_detected,
    input  logic [1:0] speed,
    output logic [2:0] state,
    output logic [2:0] drive_cmd,
    output logic [1:0] drive_speed
);

    localparam int c_hold_w = (MANUAL_HOLD    < 1) ? 1 : $clog2(MANUAL_HOLD + 1);
    localparam int c_acq_w  = (ACQUIRE_CYCLES < 1) ? 1 : $clog2(ACQUIRE_CYCLES + 1);
    localparam int c_lost_w = (LOST_TIMEOUT   < 1) ? 1 : $clog2(LOST_TIMEOUT + 1);

    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MANUAL_HOLD);
    localparam logic [c_acq_w-1:0]  c_acq_max  = c_acq_w'(ACQUIRE_CYCLES);
    localparam logic [c_lost_w-1:0] c_lost_max = c_lost_w'(LOST_TIMEOUT);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_manual = 3'd1;
    localparam logic [2:0] c_st_search = 3'd2;
    localparam logic [2:0] c_st_track  = 3'd3;
    localparam logic [2:0] c_st_halt   = 3'd4;

    localparam logic [2:0] c_cmd_stop  = 3'd0;
    localparam logic [2:0] c_cmd_fwd   = 3'd1;
    localparam logic [2:0] c_cmd_left  = 3'd3;
    localparam logic [2:0] c_cmd_right = 3'd4;
    localparam logic [2:0] c_cmd_spin  = 3'd5;

    logic [2:0]          r_state, w_state_nxt;
    logic [2:0]          r_cmd, w_cmd_nxt;
    logic [1:0]          r_spd, w_spd_nxt;
    logic [c_hold_w-1:0] r_hold, w_hold_nxt, w_hold_dec;
    logic [c_acq_w-1:0]  r_acq, w_acq_nxt, w_acq_inc;
    logic [c_lost_w-1:0] r_lost, w_lost_nxt, w_lost_inc;

    logic       w_ir_move, w_ir_stop, w_ir_manual, w_ir_search, w_ir_halt, w_ir_clear;
    logic       w_cam_valid;
    logic [2:0] w_cam_cmd;

    assign w_ir_move   = ir_valid && (IR_button >= 8'h01) && (IR_button <= 8'h04);
    assign w_ir_stop   = ir_valid && (IR_button == 8'h05);
    assign w_ir_manual = ir_valid && (IR_button == 8'h0A);
    assign w_ir_search = ir_valid && (IR_button == 8'h0B);
    assign w_ir_halt   = ir_valid && (IR_button == 8'h0C);
    assign w_ir_clear  = ir_valid && (IR_button == 8'h0D);

    // Counters saturate at their terminal value instead of wrapping.
    assign w_hold_dec = (r_hold == '0) ? r_hold : r_hold - c_hold_w'(1);
    assign w_acq_inc  = (r_acq  == c_acq_max)  ? r_acq  : r_acq  + c_acq_w'(1);
    assign w_lost_inc = (r_lost == c_lost_max) ? r_lost : r_lost + c_lost_w'(1);

    always_comb begin
        w_cam_valid = 1'b1;
        w_cam_cmd   = c_cmd_stop;
        case (cam_direction)
            3'b100:  w_cam_cmd   = c_cmd_left;
            3'b010:  w_cam_cmd   = c_cmd_fwd;
            3'b001:  w_cam_cmd   = c_cmd_right;
            default: w_cam_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_hold_nxt  = r_hold;
        w_acq_nxt   = r_acq;
        w_lost_nxt  = r_lost;

        if (w_ir_halt) begin
            w_state_nxt = c_st_halt;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_ir_manual)      w_state_nxt = c_st_manual;
                    else if (w_ir_search) w_state_nxt = c_st_search;
                end
                c_st_manual: begin
                    if (w_ir_search) begin
                        w_state_nxt = c_st_search;
                    end else if (w_ir_move) begin
                        w_cmd_nxt  = IR_button[2:0];
                        w_hold_nxt = c_hold_max;
                    end else if (w_ir_stop) begin
                        w_cmd_nxt  = c_cmd_stop;
                        w_hold_nxt = '0;
                    end else if (r_hold != '0) begin
                        w_hold_nxt = w_hold_dec;
                        if (w_hold_dec == '0) w_cmd_nxt = c_cmd_stop;
                    end
                end
                c_st_search: begin
                    if (w_ir_manual) begin
                        w_state_nxt = c_st_manual;
                    end else if (orange_detected) begin
                        w_acq_nxt = w_acq_inc;
                        if (w_acq_inc == c_acq_max) w_state_nxt = c_st_track;
                    end else begin
                        w_acq_nxt = '0;
                    end
                end
                c_st_track: begin
                    if (w_ir_manual) begin
                        w_state_nxt = c_st_manual;
                    end else if (!orange_detected && (w_lost_inc == c_lost_max)) begin
                        w_state_nxt = c_st_search;
                    end else begin
                        w_lost_nxt = orange_detected ? '0 : w_lost_inc;
                        if (w_cam_valid) w_cmd_nxt = w_cam_cmd;
                    end
                end
                c_st_halt: begin
                    if (w_ir_clear) w_state_nxt = c_st_idle;
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end

        // Any mode change restarts all timers and sets the entry command.
        if (w_state_nxt != r_state) begin
            w_hold_nxt = '0;
            w_acq_nxt  = '0;
            w_lost_nxt = '0;
            case (w_state_nxt)
                c_st_search: w_cmd_nxt = c_cmd_spin;
                c_st_track:  w_cmd_nxt = w_cam_cmd;
                default:     w_cmd_nxt = c_cmd_stop;
            endcase
        end

        w_spd_nxt = ((w_state_nxt == c_st_manual) || (w_state_nxt == c_st_search) ||
                     (w_state_nxt == c_st_track)) ? speed : 2'd0;
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cmd   <= c_cmd_stop;
            r_spd   <= 2'd0;
            r_hold  <= '0;
            r_acq   <= '0;
            r_lost  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_spd   <= w_spd_nxt;
            r_hold  <= w_hold_nxt;
            r_acq   <= w_acq_nxt;
            r_lost  <= w_lost_nxt;
        end
    end

    assign state       = r_state;
    assign drive_cmd   = r_cmd;
    assign drive_speed = r_spd;

endmodule

`default_nettype wire

// File: tb/tb_robot_mode_controller.sv
// ============================================================================
//  Module      : tb_robot_mode_controller
//  Description : Vector table, directed corner sequences and random traffic
//                against a behavioural mode model for robot_mode_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_robot_mode_controller;

    localparam int c_hold = 8;
    localparam int c_acq  = 4;
    localparam int c_lost = 16;

    logic       clk_50 = 1'b0;
    logic       reset = 1'b0;
    logic       ir_valid = 1'b0;
    logic [7:0] IR_button = 8'h00;
    logic [2:0] cam_direction = 3'b000;
    logic       orange_detected = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [2:0] state;
    logic [2:0] drive_cmd;
    logic [1:0] drive_speed;

    robot_mode_controller #(
        .MANUAL_HOLD   (c_hold),
        .ACQUIRE_CYCLES(c_acq),
        .LOST_TIMEOUT  (c_lost)
    ) dut (
        .clk_50         (clk_50),
        .reset          (reset),
        .ir_valid       (ir_valid),
        .IR_button      (IR_button),
        .cam_direction  (cam_direction),
        .orange_detected(orange_detected),
        .speed          (speed),
        .state          (state),
        .drive_cmd      (drive_cmd),
        .drive_speed    (drive_speed)
    );

    always #5 clk_50 = ~clk_50;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [7:0] code;
        logic [2:0] cam;
        logic       org;
        logic [1:0] sp;
        logic [2:0] es;
        logic [2:0] ec;
        logic [1:0] ep;
    } vec_t;

    vec_t tbl[$];

    // Model of the robot's behaviour: mode, command, speed and run lengths.
    int m_mode, m_cmd, m_spd, m_hold_left, m_high_run, m_low_run;

    task automatic check(input string name, input logic [2:0] es, input logic [2:0] ec,
                         input logic [1:0] ep);
        total++;
        if (state !== es || drive_cmd !== ec || drive_speed !== ep) begin
            bad++;
            $display("FAIL %s t=%0t: got state=%0d cmd=%0d spd=%0d, want state=%0d cmd=%0d spd=%0d",
                     name, $time, state, drive_cmd, drive_speed, es, ec, ep);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] code, input logic [2:0] cam,
                         input logic org, input logic [1:0] sp);
        ir_valid        = v;
        IR_button       = code;
        cam_direction   = cam;
        orange_detected = org;
        speed           = sp;
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic step(input logic v, input logic [7:0] code, input logic [2:0] cam,
                        input logic org, input logic [1:0] sp, input string name,
                        input logic [2:0] es, input logic [2:0] ec, input logic [1:0] ep);
        drive(v, code, cam, org, sp);
        tick();
        check(name, es, ec, ep);
    endtask

    function automatic int cam_cmd(input logic [2:0] cam, input int keep);
        if (cam == 3'b100) return 3;
        if (cam == 3'b010) return 1;
        if (cam == 3'b001) return 4;
        return keep;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cmd = 0; m_spd = 0;
        m_hold_left = 0; m_high_run = 0; m_low_run = 0;
    endtask

    task automatic model_step();
        int  nm, nc, code;
        bit  hit;
        nm   = m_mode;
        nc   = m_cmd;
        hit  = ir_valid;
        code = int'(IR_button);
        if (hit && code == 'h0C) nm = 4;
        else if (m_mode == 0) begin
            if (hit && code == 'h0A) nm = 1;
            else if (hit && code == 'h0B) nm = 2;
        end else if (m_mode == 1) begin
            if (hit && code == 'h0B) nm = 2;
            else if (hit && code >= 1 && code <= 4) begin nc = code; m_hold_left = c_hold; end
            else if (hit && code == 5) begin nc = 0; m_hold_left = 0; end
            else if (m_hold_left > 0) begin
                m_hold_left--;
                if (m_hold_left == 0) nc = 0;
            end
        end else if (m_mode == 2) begin
            if (hit && code == 'h0A) nm = 1;
            else if (orange_detected) begin
                m_high_run++;
                if (m_high_run >= c_acq) nm = 3;
            end else m_high_run = 0;
        end else if (m_mode == 3) begin
            if (hit && code == 'h0A) nm = 1;
            else begin
                m_low_run = orange_detected ? 0 : m_low_run + 1;
                if (m_low_run >= c_lost) nm = 2;
                else nc = cam_cmd(cam_direction, m_cmd);
            end
        end else begin
            if (hit && code == 'h0D) nm = 0;
        end
        if (nm != m_mode) begin
            m_hold_left = 0; m_high_run = 0; m_low_run = 0;
            nc = (nm == 2) ? 5 : (nm == 3) ? cam_cmd(cam_direction, 0) : 0;
        end
        m_mode = nm;
        m_cmd  = nc;
        m_spd  = (nm >= 1 && nm <= 3) ? int'(speed) : 0;
    endtask

    task automatic add(input logic v, input logic [7:0] code, input logic [1:0] sp,
                       input logic [2:0] es, input logic [2:0] ec, input logic [1:0] ep);
        tbl.push_back('{v, code, 3'b000, 1'b0, sp, es, ec, ep});
    endtask

    logic [7:0] codes [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0A, 8'h0B,
                               8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0D, 8'h55, 8'h00};

    initial begin
        logic org;

        // IR mode/manual table.
        add(1, 8'h55, 0, 0, 0, 0);
        add(1, 8'h01, 2, 0, 0, 0);
        add(1, 8'h0A, 2, 1, 0, 2);
        add(1, 8'h01, 2, 1, 1, 2);
        for (int i = 0; i < 7; i++) add(0, 8'h00, 2, 1, 1, 2);
        add(0, 8'h00, 2, 1, 0, 2);
        add(1, 8'h04, 1, 1, 4, 1);
        add(1, 8'h05, 1, 1, 0, 1);
        add(1, 8'h0D, 1, 1, 0, 1);
        add(1, 8'h0C, 1, 4, 0, 0);
        add(1, 8'h0A, 1, 4, 0, 0);
        add(1, 8'h01, 1, 4, 0, 0);
        add(1, 8'h0D, 1, 0, 0, 0);
        add(1, 8'h0B, 3, 2, 5, 3);
        add(1, 8'h0A, 3, 1, 0, 3);
        add(1, 8'h0B, 3, 2, 5, 3);

        #1 reset = 1'b1;
        #1 check("reset_async", 3'd0, 3'd0, 2'd0);
        drive(1, 8'h0A, 3'b010, 1, 3);
        tick();
        check("reset_held_clk", 3'd0, 3'd0, 2'd0);
        tick();
        reset = 1'b0;

        foreach (tbl[i])
            step(tbl[i].v, tbl[i].code, tbl[i].cam, tbl[i].org, tbl[i].sp,
                 $sformatf("tbl%0d", i), tbl[i].es, tbl[i].ec, tbl[i].ep);

        // Acquire with a broken pulse train.
        for (int i = 0; i < 3; i++) step(0, 8'h00, 3'b000, 1, 3, "acq_first", 2, 5, 3);
        step(0, 8'h00, 3'b000, 0, 3, "acq_gap", 2, 5, 3);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 3'b000, 1, 3, "acq_run", 2, 5, 3);
        step(0, 8'h00, 3'b000, 1, 3, "acq_enter_track", 3, 0, 3);

        // Steering and loss of target.
        step(0, 8'h00, 3'b100, 1, 3, "trk_left", 3, 3, 3);
        step(0, 8'h00, 3'b010, 1, 3, "trk_centre", 3, 1, 3);
        step(0, 8'h00, 3'b000, 1, 3, "trk_nodir", 3, 1, 3);
        for (int i = 0; i < 15; i++) step(0, 8'h00, 3'b000, 0, 3, "trk_lowrun", 3, 1, 3);
        step(0, 8'h00, 3'b000, 0, 3, "trk_lost", 2, 5, 3);

        // HALT on the same cycle as lost-timeout expiry.
        for (int i = 0; i < 3; i++) step(0, 8'h00, 3'b000, 1, 2, "reacq", 2, 5, 2);
        step(0, 8'h00, 3'b001, 1, 2, "reacq_right", 3, 4, 2);
        for (int i = 0; i < 15; i++) step(0, 8'h00, 3'b000, 0, 2, "halt_lowrun", 3, 4, 2);
        step(1, 8'h0C, 3'b000, 0, 2, "halt_vs_lost", 4, 0, 0);
        step(0, 8'h00, 3'b000, 0, 2, "halt_stays", 4, 0, 0);
        step(1, 8'h0A, 3'b000, 0, 2, "halt_ign_0a", 4, 0, 0);
        step(1, 8'h01, 3'b000, 0, 2, "halt_ign_01", 4, 0, 0);
        step(1, 8'h0D, 3'b000, 0, 2, "halt_clear", 0, 0, 0);

        // Asynchronous reset during MANUAL FWD.
        step(1, 8'h0A, 3'b000, 0, 2, "man_enter", 1, 0, 2);
        step(1, 8'h01, 3'b000, 0, 2, "man_fwd", 1, 1, 2);
        drive(0, 8'h00, 3'b000, 0, 2);
        #3 reset = 1'b1;
        #1 check("reset_midcycle", 0, 0, 0);
        #2 reset = 1'b0;
        tick();
        check("reset_release", 0, 0, 0);
        step(1, 8'h0A, 3'b000, 0, 1, "after_reset", 1, 0, 1);

        // Random traffic against the model.
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        org = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) org = ~org;
            drive($urandom_range(0, 3) == 0, codes[$urandom_range(0, 13)],
                  3'($urandom_range(0, 7)), org, 2'($urandom_range(0, 3)));
            model_step();
            tick();
            check($sformatf("rand%0d", i), 3'(m_mode), 3'(m_cmd), 2'(m_spd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
